chromosome_serial_loader: RTL

Serial front end of the evolution loop, sitting directly upstream of the chromosome processing state machine. It receives a framed 992-bit chromosome description over a byte stream, stages it in a shadow register, and commits it atomically. It then hands the chromosome to the processing machine through its start/ready/done/feedback handshake and captures the eight 32-bit per-output error sums. Finally it streams those sums back as 32 bytes.

---
 rtl/chromosome_serial_loader_pkg.sv | 20 ++
 rtl/chromosome_serial_loader_if.sv | 26 ++
 rtl/chromosome_serial_loader_result_serializer.sv | 47 ++++
 rtl/chromosome_serial_loader.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/chromosome_serial_loader_pkg.sv
// Shared definitions for the chromosome serial link: loader states, framing
// constants and result stream geometry.
package chromosome_link_pkg;

    localparam int unsigned CHROM_BITS   = 992;
    localparam logic [7:0]  FRAME_HEADER = 8'h55;
    localparam int unsigned RESULT_BYTES = 32;
    localparam int unsigned RESULT_BITS  = RESULT_BYTES * 8;
    localparam int unsigned NUM_SUMS     = 8;
    localparam int unsigned SUM_BITS     = 32;

    typedef enum logic [2:0] {
        S_HEADER    = 3'd0,
        S_PAYLOAD   = 3'd1,
        S_START     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_TX        = 3'd4
    } state_t;

endpackage

// File: rtl/chromosome_serial_loader_if.sv
// Byte-stream link of the loader: strobed RX bytes in, valid/ready TX bytes out.
interface chromosome_serial_loader_if;

    logic [7:0] iRxData;
    logic       iRxValid;
    logic [7:0] oTxData;
    logic       oTxValid;
    logic       iTxReady;

    modport master (
        output iRxData,
        output iRxValid,
        output iTxReady,
        input  oTxData,
        input  oTxValid
    );

    modport slave (
        input  iRxData,
        input  iRxValid,
        input  iTxReady,
        output oTxData,
        output oTxValid
    );

endinterface

// File: rtl/chromosome_serial_loader_result_serializer.sv
// Holds the captured error sums and streams them out MSB byte first under
// valid/ready; oDone pulses with the acceptance of the final byte.
module result_serializer
    import chromosome_link_pkg::*;
(
    input  logic                   iClock,
    input  logic                   iReset,
    input  logic                   iLoad,
    input  logic [RESULT_BITS-1:0] iData,
    input  logic                   iTxReady,
    output logic [7:0]             oTxData,
    output logic                   oTxValid,
    output logic                   oDone
);

    localparam int unsigned      CNT_W     = $clog2(RESULT_BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(RESULT_BYTES - 1);

    logic [RESULT_BITS-1:0] shiftReg;
    logic [CNT_W-1:0]       byteCount;
    logic                   busy;
    logic                   accept;

    assign accept   = busy && iTxReady;
    assign oTxData  = shiftReg[RESULT_BITS-1 -: 8];
    assign oTxValid = busy;
    assign oDone    = accept && (byteCount == LAST_BYTE);

    always_ff @(posedge iClock) begin
        if (iReset) begin
            shiftReg  <= '0;
            byteCount <= '0;
            busy      <= 1'b0;
        end else if (iLoad) begin
            shiftReg  <= iData;
            byteCount <= '0;
            busy      <= 1'b1;
        end else if (accept) begin
            shiftReg  <= {shiftReg[RESULT_BITS-9:0], 8'h00};
            byteCount <= byteCount + 1'b1;
            if (byteCount == LAST_BYTE) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/chromosome_serial_loader.sv
// Serial front end of the evolution loop: receives a framed chromosome, commits
// it atomically, runs the processing handshake and streams back the error sums.
module chromosome_serial_loader #(
    parameter int unsigned CHROM_BITS     = chromosome_link_pkg::CHROM_BITS,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                         iClock,
    input  logic                         iReset,
    chromosome_serial_loader_if.slave    link,
    output logic [CHROM_BITS-1:0]        oChromDescription,
    output logic                         oStartProcessing,
    input  logic                         iReadyToProcess,
    input  logic                         iDoneProcessing,
    output logic                         oDoneProcessingFeedback,
    input  logic [7:0][31:0]             iErrorSums,
    output logic [2:0]                   oState,
    output logic [7:0]                   oFrameErrors
);

    import chromosome_link_pkg::*;

    localparam int unsigned     CHROM_BYTES = CHROM_BITS / 8;
    localparam int unsigned     TO_W        = $clog2(TIMEOUT_CYCLES);
    localparam logic [6:0]      LAST_RX     = 7'(CHROM_BYTES - 1);
    localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);

    state_t                 state;
    state_t                 stateNext;
    logic [CHROM_BITS-1:0]  shadow;
    logic [CHROM_BITS-1:0]  shadowShifted;
    logic [6:0]             rxCount;
    logic [TO_W-1:0]        idleCount;
    logic                   headerSeen;
    logic                   lastByte;
    logic                   timeout;
    logic                   loadResult;
    logic                   txDone;
    logic [RESULT_BITS-1:0] resultWord;

    assign shadowShifted = {shadow[CHROM_BITS-9:0], link.iRxData};
    assign oState        = state;

    // Result register order is {sum[0], ..., sum[7]} so sum[0] leaves first.
    always_comb begin
        resultWord = '0;
        for (int unsigned i = 0; i < NUM_SUMS; i++) begin
            resultWord[RESULT_BITS-1-SUM_BITS*i -: SUM_BITS] = iErrorSums[i];
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state <= S_HEADER;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext               = state;
        oStartProcessing        = 1'b0;
        oDoneProcessingFeedback = 1'b0;
        headerSeen              = 1'b0;
        lastByte                = 1'b0;
        timeout                 = 1'b0;
        loadResult              = 1'b0;
        case (state)
            S_HEADER: begin
                if (link.iRxValid && (link.iRxData == FRAME_HEADER)) begin
                    headerSeen = 1'b1;
                    stateNext  = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                // A byte arriving on the timeout cycle takes priority.
                if (link.iRxValid) begin
                    if (rxCount == LAST_RX) begin
                        lastByte  = 1'b1;
                        stateNext = S_START;
                    end
                end else if (idleCount == TO_LAST) begin
                    timeout   = 1'b1;
                    stateNext = S_HEADER;
                end
            end
            S_START: begin
                oStartProcessing = 1'b1;
                if (iReadyToProcess) begin
                    stateNext = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (iDoneProcessing) begin
                    oDoneProcessingFeedback = 1'b1;
                    loadResult              = 1'b1;
                    stateNext               = S_TX;
                end
            end
            S_TX: begin
                if (txDone) begin
                    stateNext = S_HEADER;
                end
            end
            default: stateNext = S_HEADER;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            shadow            <= '0;
            oChromDescription <= '0;
            rxCount           <= '0;
            idleCount         <= '0;
            oFrameErrors      <= '0;
        end else begin
            if (headerSeen) begin
                rxCount   <= '0;
                idleCount <= '0;
            end
            if (state == S_PAYLOAD) begin
                if (link.iRxValid) begin
                    shadow    <= shadowShifted;
                    rxCount   <= rxCount + 1'b1;
                    idleCount <= '0;
                    if (lastByte) begin
                        oChromDescription <= shadowShifted;
                    end
                end else if (timeout) begin
                    idleCount <= '0;
                    if (oFrameErrors != 8'hFF) begin
                        oFrameErrors <= oFrameErrors + 1'b1;
                    end
                end else begin
                    idleCount <= idleCount + 1'b1;
                end
            end
        end
    end

    result_serializer uSerializer (
        .iClock   (iClock),
        .iReset   (iReset),
        .iLoad    (loadResult),
        .iData    (resultWord),
        .iTxReady (link.iTxReady),
        .oTxData  (link.oTxData),
        .oTxValid (link.oTxValid),
        .oDone    (txDone)
    );

endmodule
